// File: rtl/pll_cfg_responder_if.sv
// Avalon-MM management port between the underclock sequencer (master)
// and the PLL reconfiguration responder (slave).
interface pll_cfg_responder_if;
  logic        mgmt_write;
  logic        mgmt_read;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest;

  modport master (
    output mgmt_write, mgmt_read, mgmt_address, mgmt_writedata,
    input  mgmt_readdata, mgmt_waitrequest
  );

  modport slave (
    input  mgmt_write, mgmt_read, mgmt_address, mgmt_writedata,
    output mgmt_readdata, mgmt_waitrequest
  );
endinterface

// File: rtl/pll_cfg_responder.sv
// Behavioural stand-in for the PLL reconfiguration IP. Holds MODE and
// fractional-K shadow registers; a START write launches a fixed-length
// apply, after which the shadowed K is copied to frac_k. During the apply
// the bus is stalled (waitrequest mode) or busy is reported via STATUS
// (polling mode).
module pll_cfg_responder #(
  parameter int unsigned APPLY_CYCLES = 16,
  parameter logic [31:0] RESET_FRAC   = 32'd3639383488
) (
  input  logic                 clk,
  input  logic                 reset,
  pll_cfg_responder_if.slave   mgmt,
  output logic [31:0]          frac_k,
  output logic                 apply_pulse,
  output logic                 locked
);

  localparam int unsigned       CNT_W    = $clog2(APPLY_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(APPLY_CYCLES - 1);

  localparam logic [5:0] ADDR_MODE   = 6'd0;
  localparam logic [5:0] ADDR_STATUS = 6'd1;
  localparam logic [5:0] ADDR_START  = 6'd2;
  localparam logic [5:0] ADDR_K      = 6'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             mode, mode_n;
  logic [31:0]      shadow, shadow_n;
  logic [31:0]      frac_n;
  logic             pulse_n;
  logic [31:0]      rdata_n;
  logic             wait_n;
  logic             wr_acc, rd_acc;

  // A request only counts when the bus is not stalled; a write shadows a
  // simultaneous read, which is simply dropped.
  assign wr_acc = mgmt.mgmt_write && !mgmt.mgmt_waitrequest;
  assign rd_acc = mgmt.mgmt_read && !mgmt.mgmt_write && !mgmt.mgmt_waitrequest;

  assign locked = (state == ST_IDLE);

  // Next-state, register-file and read-data logic.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_n  = state;
    cnt_n    = cnt;
    mode_n   = mode;
    shadow_n = shadow;
    frac_n   = frac_k;
    pulse_n  = 1'b0;
    rdata_n  = mgmt.mgmt_readdata;

    unique case (state)
      ST_IDLE: begin
        if (wr_acc && mgmt.mgmt_address == ADDR_START) begin
          state_n = ST_APPLY;
          cnt_n   = CNT_LOAD;
        end
      end
      ST_APPLY: begin
        if (cnt == '0) begin
          // Uses the shadow as registered this cycle; a K write accepted in
          // the same cycle lands in the shadow only.
          state_n = ST_IDLE;
          frac_n  = shadow;
          pulse_n = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (wr_acc) begin
      if (mgmt.mgmt_address == ADDR_MODE) mode_n   = mgmt.mgmt_writedata[0];
      if (mgmt.mgmt_address == ADDR_K)    shadow_n = mgmt.mgmt_writedata;
    end

    if (rd_acc) begin
      unique case (mgmt.mgmt_address)
        ADDR_MODE:   rdata_n = {31'b0, mode};
        ADDR_STATUS: rdata_n = {31'b0, (state == ST_IDLE)};
        ADDR_K:      rdata_n = shadow;
        default:     rdata_n = 32'b0;
      endcase
    end

    // Derived from next-state values so the registered stall lines up with
    // the state it describes, including a MODE change made mid-apply.
    wait_n = (state_n == ST_APPLY) && !mode_n;
  end

  // State and register update with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their inputs from the same pre-edge values.
    if (reset) begin
      state                 <= ST_IDLE;
      cnt                   <= '0;
      mode                  <= 1'b0;
      shadow                <= RESET_FRAC;
      frac_k                <= RESET_FRAC;
      apply_pulse           <= 1'b0;
      mgmt.mgmt_readdata    <= 32'b0;
      mgmt.mgmt_waitrequest <= 1'b0;
    end else begin
      state                 <= state_n;
      cnt                   <= cnt_n;
      mode                  <= mode_n;
      shadow                <= shadow_n;
      frac_k                <= frac_n;
      apply_pulse           <= pulse_n;
      mgmt.mgmt_readdata    <= rdata_n;
      mgmt.mgmt_waitrequest <= wait_n;
    end
  end

endmodule

// File: doc/pll_cfg_responder.md
# pll_cfg_responder

Avalon-MM slave that answers the PLL reconfiguration management port driven by the top-level underclock sequencer. It holds waitrequest-mode and fractional-K shadow registers, and applies the shadowed K to its active output after a start command and a fixed busy period. Across that period it stalls the bus (waitrequest mode) or reports busy through a status register (polling mode). It is the behavioural stand-in for the PLL reconfig IP used in core-level simulation and in the lock/handshake regression.

## Interface
Parameters:
- APPLY_CYCLES, 16: busy cycles between an accepted start and the apply; must be ≥1.
- RESET_FRAC, 32'd3639383488: reset value of the shadow and active fractional K (native speed).

Ports:
- clk  in  1  sole clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- mgmt_write  in  1  write request.
- mgmt_read  in  1  read request.
- mgmt_address  in  6  register address.
- mgmt_writedata  in  32  write data.
- mgmt_readdata  out  32  registered read data; reset 0.
- mgmt_waitrequest  out  1  bus stall; reset 0.
- frac_k  out  32  active fractional K; reset RESET_FRAC.
- apply_pulse  out  1  one-cycle strobe when frac_k updates; reset 0.
- locked  out  1  low while an apply is in progress; reset 1.

## Operation
- Acceptance: a request is accepted in a cycle where it is asserted and mgmt_waitrequest is 0.
- Write priority: if write and read are both asserted, only the write is accepted. The read is dropped and readdata holds.
- Register map:
  - Addr 0, MODE: bit0 stored; 0 = waitrequest mode, 1 = polling mode. Reads return {31'b0, mode}.
  - Addr 1, STATUS: read-only; bit0 = 1 when IDLE. Writes are ignored.
  - Addr 2, START: any write data starts an apply when the FSM is IDLE. A START accepted in APPLY (polling mode only) is ignored. Reads return 0.
  - Addr 7, K: 32-bit shadow. Reads return the shadow, not frac_k.
  - All other addresses: writes ignored, reads return 0.
- FSM states: IDLE and APPLY.
  - IDLE → APPLY on an accepted START; load cnt = APPLY_CYCLES−1.
  - In APPLY, cnt decrements each cycle. When cnt == 0: return to IDLE, set frac_k ← shadow, assert apply_pulse for one cycle.
- mgmt_waitrequest = (state == APPLY) && (mode == 0). It is registered alongside the state, with no combinational path from bus inputs.
- Polling mode: K writes accepted during APPLY update the shadow only. The in-flight apply uses the shadow value registered on the last cycle of APPLY.
- locked = (state == IDLE).
- A MODE write accepted during APPLY (polling mode) takes effect on the next cycle. This can raise waitrequest for the rest of APPLY.
- Reset: state IDLE, cnt 0, mode 0, shadow = frac_k = RESET_FRAC, readdata 0, apply_pulse 0, locked 1. Reset mid-APPLY aborts with no pulse and no frac_k change other than the reset value.

## Timing
- Register writes: value visible on the cycle after acceptance.
- Reads: accepted in cycle T; mgmt_readdata is valid from T+1 and holds until the next accepted read or reset.
- START accepted in cycle T:
  - cycles T+1 … T+APPLY_CYCLES: state APPLY, locked 0, waitrequest high if mode 0.
  - cycle T+APPLY_CYCLES+1: state IDLE, frac_k updated, apply_pulse 1, locked 1, waitrequest 0.
- A request held through waitrequest is accepted in the first cycle waitrequest is 0, i.e. T+APPLY_CYCLES+1.
- Back-to-back: a START accepted in the cycle apply_pulse is high begins a new APPLY immediately.
- cnt width is $clog2(APPLY_CYCLES+1). With APPLY_CYCLES = 1, APPLY lasts exactly one cycle.

## Test plan
- Reset, then idle 5 cycles → frac_k = 3639383488, locked 1, waitrequest 0, apply_pulse 0, readdata 0.
- Write 0←0, 7←2971430088, 2←0 on consecutive cycles; START accepted at T → waitrequest high T+1…T+16; at T+17 frac_k = 2971430088 with a single-cycle apply_pulse.
- Mode 1: write START, then read addr 1 every cycle → readdata bit0 = 0 for 16 reads, then 1; waitrequest never asserted.
- Mode 0: assert a write to 7←0x12345678 at T+3 during APPLY and hold it → not accepted until T+17; shadow updated from T+18; frac_k keeps the first value.
- Reset asserted at T+8 of an apply → no apply_pulse; frac_k = shadow = 3639383488, locked 1 on the cycle after reset.
- Simultaneous read of 7 and write 7←5 → shadow = 5; readdata unchanged; a following read of 7 returns 5.
